// File: rtl/prod_accum_pkg.sv
// Shared types and default sizes for the product accumulator.
package prod_accum_pkg;

  localparam int PROD_W_DEFAULT  = 64;
  localparam int GUARD_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/prod_accum.sv
// Accumulates a run of len products from the multiplier stage and hands the
// guard-extended sum downstream with a valid/ready handshake.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEFAULT,
  parameter int GUARD_W = GUARD_W_DEFAULT,
  localparam int ACC_W  = PROD_W + GUARD_W,
  localparam int CNT_W  = GUARD_W + 1
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               start,
  input  logic [GUARD_W-1:0] len,
  input  logic [PROD_W-1:0]  prod,
  input  logic               prod_valid,
  output logic               prod_ready,
  output logic [ACC_W-1:0]   sum,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   rem_q, rem_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    prod_ready = 1'b0;
    sum_valid  = 1'b0;
    busy       = 1'b0;
    sum        = acc_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // A length of zero encodes the full 2^GUARD_W run.
          rem_d   = (len == '0) ? {1'b1, {GUARD_W{1'b0}}} : {1'b0, len};
          acc_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        prod_ready = 1'b1;
        busy       = 1'b1;
        if (prod_valid) begin
          acc_d = acc_q + {{GUARD_W{1'b0}}, prod};
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        sum_valid = 1'b1;
        busy      = 1'b1;
        if (sum_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prod_accum.sv
// Randomized self-checking bench for prod_accum against a run-sum reference model.
module tb_prod_accum;

  localparam int PW = 64;
  localparam int GW = 8;
  localparam int AW = PW + GW;

  logic          CLK = 1'b0;
  logic          rst, start, prod_valid, sum_ready;
  logic          prod_ready, sum_valid, busy;
  logic [GW-1:0] len;
  logic [PW-1:0] prod;
  logic [AW-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  prod_accum dut (
    .CLK        (CLK),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .sum        (sum),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .busy       (busy)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_run(input logic [GW-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = GW'($urandom);
  endtask

  task automatic feed(input logic [PW-1:0] v, input int gap);
    prod_valid = 1'b0;
    repeat (gap) tick();
    prod_valid = 1'b1;
    prod       = v;
    tick();
    prod_valid = 1'b0;
    prod       = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 8'd3; prod_valid = 1'b1; prod = 64'd42; sum_ready = 1'b0;
    repeat (3) tick();
    n_cmp++; if (prod_ready !== 1'b0) begin n_err++; $display("FAIL reset_prod_ready: got %b want 0", prod_ready); end
    n_cmp++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL reset_sum_valid: got %b want 0", sum_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL reset_sum: got %h want 0", sum); end
    rst = 1'b0; start = 1'b0; prod_valid = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_release_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [PW-1:0] q [$];
    logic [AW-1:0] exp;
    q = '{64'd5, 64'd7, 64'd11};
    exp = '0;
    foreach (q[i]) exp = exp + AW'(q[i]);
    sum_ready = 1'b1;
    start_run(8'd3);
    n_cmp++; if (prod_ready !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL basic_accum_entry: ready/busy got %b%b want 11", prod_ready, busy); end
    foreach (q[i]) feed(q[i], 0);
    n_cmp++; if (sum_valid !== 1'b1 || sum !== exp) begin n_err++; $display("FAIL basic_sum: got valid %b sum %0d want valid 1 sum %0d", sum_valid, sum, exp); end
    tick();
    n_cmp++; if (sum_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_one_cycle: valid/busy got %b%b want 00", sum_valid, busy); end
    // IDLE ignores products and keeps the last sum visible.
    prod_valid = 1'b1; prod = 64'd99;
    repeat (3) tick();
    prod_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0 || prod_ready !== 1'b0 || sum !== exp) begin n_err++; $display("FAIL idle_hold: busy %b ready %b sum %0d want 0 0 %0d", busy, prod_ready, sum, exp); end
  endtask

  task automatic test_full_len0();
    sum_ready = 1'b1;
    start_run(8'd0);
    for (int i = 0; i < 255; i++) feed('1, 0);
    n_cmp++; if (busy !== 1'b1 || sum_valid !== 1'b0) begin n_err++; $display("FAIL full_not_early: busy/valid got %b%b want 10", busy, sum_valid); end
    feed('1, 0);
    n_cmp++; if (sum_valid !== 1'b1 || sum !== 72'hFF_FFFF_FFFF_FFFF_FF00) begin n_err++; $display("FAIL full_sum: got valid %b sum %h want 1 ffffffffffffffff00", sum_valid, sum); end
    tick();
  endtask

  task automatic test_gaps_and_start_ignored();
    sum_ready = 1'b1;
    start_run(8'd2);
    feed(64'd100, 0);
    for (int c = 0; c < 3; c++) begin
      start = 1'b1; len = 8'd1;
      tick();
      n_cmp++; if (sum !== 72'd100 || sum_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL gap_hold_%0d: sum %0d valid %b busy %b want 100 0 1", c, sum, sum_valid, busy); end
    end
    start = 1'b0;
    feed(64'd200, 0);
    n_cmp++; if (sum_valid !== 1'b1 || sum !== 72'd300) begin n_err++; $display("FAIL gap_sum: valid %b sum %0d want 1 300", sum_valid, sum); end
    tick();
  endtask

  task automatic test_hold();
    logic [AW-1:0] exp;
    logic [PW-1:0] v;
    int n;
    n = $urandom_range(5, 1);
    exp = '0;
    sum_ready = 1'b0;
    start_run(GW'(n));
    for (int i = 0; i < n; i++) begin
      v = {$urandom, $urandom};
      exp = exp + AW'(v);
      feed(v, $urandom_range(2, 0));
    end
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (sum_valid !== 1'b1 || sum !== exp) begin n_err++; $display("FAIL hold_%0d: valid %b sum %h want 1 %h", c, sum_valid, sum, exp); end
      start = c[0]; len = 8'd1;
      tick();
    end
    start = 1'b0;
    sum_ready = 1'b1;
    tick();
    n_cmp++; if (sum_valid !== 1'b0 || busy !== 1'b0 || sum !== exp) begin n_err++; $display("FAIL hold_release: valid %b busy %b sum %h want 0 0 %h", sum_valid, busy, sum, exp); end
  endtask

  task automatic test_reset_mid();
    sum_ready = 1'b1;
    start_run(8'd4);
    feed(64'd1000, 0);
    feed(64'd2000, 0);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || prod_ready !== 1'b0 || sum_valid !== 1'b0 || sum !== '0) begin n_err++; $display("FAIL mid_reset: busy %b ready %b valid %b sum %0d want 0 0 0 0", busy, prod_ready, sum_valid, sum); end
    @(posedge CLK); #1 rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_idle: busy got %b want 0", busy); end
    start_run(8'd1);
    feed(64'd9, 0);
    n_cmp++; if (sum_valid !== 1'b1 || sum !== 72'd9) begin n_err++; $display("FAIL mid_reset_fresh: valid %b sum %0d want 1 9", sum_valid, sum); end
    tick();
  endtask

  task automatic test_back_to_back();
    sum_ready = 1'b1;
    start_run(8'd2);
    feed(64'd40, 0);
    start = 1'b1; len = 8'd1;
    feed(64'd2, 0);
    n_cmp++; if (sum_valid !== 1'b1 || sum !== 72'd42) begin n_err++; $display("FAIL b2b_first: valid %b sum %0d want 1 42", sum_valid, sum); end
    tick();
    n_cmp++; if (sum_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: valid/busy got %b%b want 00", sum_valid, busy); end
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || prod_ready !== 1'b1 || sum !== '0) begin n_err++; $display("FAIL b2b_restart: busy %b ready %b sum %0d want 1 1 0", busy, prod_ready, sum); end
    feed(64'd77, 0);
    n_cmp++; if (sum_valid !== 1'b1 || sum !== 72'd77) begin n_err++; $display("FAIL b2b_second: valid %b sum %0d want 1 77", sum_valid, sum); end
    tick();
  endtask

  task automatic test_random();
    logic [PW-1:0] q [$];
    logic [AW-1:0] exp;
    int n, d;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(12, 1);
      d = $urandom_range(3, 0);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back({$urandom, $urandom});
      exp = '0;
      foreach (q[i]) exp = exp + AW'(q[i]);
      sum_ready = 1'b0;
      start_run(GW'(n));
      foreach (q[i]) feed(q[i], $urandom_range(2, 0));
      repeat (d) tick();
      n_cmp++; if (sum_valid !== 1'b1 || sum !== exp) begin n_err++; $display("FAIL rand_%0d: len %0d valid %b sum %h want 1 %h", r, n, sum_valid, sum, exp); end
      sum_ready = 1'b1;
      tick();
      n_cmp++; if (sum_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rand_release_%0d: valid/busy got %b%b want 00", r, sum_valid, busy); end
    end
  endtask

  task automatic test_bin_mult();
    logic [31:0] a [2];
    logic [31:0] b [2];
    a = '{32'hFFFF_FFFF, 32'd3};
    b = '{32'd2, 32'd4};
    sum_ready = 1'b1;
    start_run(8'd2);
    // The multiplier's product arrives one cycle after its operands.
    prod_valid = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) feed(PW'(a[i]) * PW'(b[i]), 0);
    n_cmp++; if (sum_valid !== 1'b1 || sum !== 72'h2_0000_000A) begin n_err++; $display("FAIL bin_mult_sum: valid %b sum %h want 1 20000000a", sum_valid, sum); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_len0();
    test_gaps_and_start_ignored();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_bin_mult();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
